// File: rtl/hvac_actuator_seq_if.sv
// Mode request and actuator status bundle between the mode FSM, this
// sequencer and any observer.
interface hvac_actuator_seq_if;
   logic [1:0] mode_req;
   logic       heater_en;
   logic       cooler_en;
   logic       busy;
   logic       illegal_req;
   logic [1:0] state_o;

   modport master (
      output mode_req,
      input  heater_en, cooler_en, busy, illegal_req, state_o
   );

   modport slave (
      input  mode_req,
      output heater_en, cooler_en, busy, illegal_req, state_o
   );
endinterface

// File: rtl/hvac_actuator_seq.sv
// Heater/cooler enable sequencer: enforces a minimum on-time per actuator and
// a fixed dead-time between one actuator dropping and any actuator rising.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | both actuators off, waiting for a heat/cool request
// HEAT  | heater driven; held for at least MIN_ON cycles
// COOL  | cooler driven; held for at least MIN_ON cycles
// DEAD  | both off for exactly DEAD_T cycles, request evaluated on exit
module hvac_actuator_seq #(
   parameter int MIN_ON = 8,
   parameter int DEAD_T = 4,
   parameter int CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   hvac_actuator_seq_if.slave  act
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] HEAT = 2'b01;
   localparam logic [1:0] COOL = 2'b10;
   localparam logic [1:0] DEAD = 2'b11;

   localparam logic [1:0] REQ_IDLE = 2'b00;
   localparam logic [1:0] REQ_COOL = 2'b01;
   localparam logic [1:0] REQ_HEAT = 2'b10;

   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_T - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       req_eff;
   logic             heater_q;
   logic             cooler_q;
   logic             illegal_q;

   // An illegal request behaves exactly like an idle request.
   assign req_eff = (act.mode_req == 2'b11) ? REQ_IDLE : act.mode_req;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_eff == REQ_HEAT)      state_nxt = HEAT;
            else if (req_eff == REQ_COOL) state_nxt = COOL;
         end
         HEAT: begin
            if ((req_eff != REQ_HEAT) && (cnt >= ON_LAST)) state_nxt = DEAD;
         end
         COOL: begin
            if ((req_eff != REQ_COOL) && (cnt >= ON_LAST)) state_nxt = DEAD;
         end
         default: begin
            if (cnt == DEAD_LAST) begin
               case (req_eff)
                  REQ_HEAT: state_nxt = HEAT;
                  REQ_COOL: state_nxt = COOL;
                  default:  state_nxt = IDLE;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         heater_q  <= 1'b0;
         cooler_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         heater_q  <= (state_nxt == HEAT);
         cooler_q  <= (state_nxt == COOL);
         illegal_q <= (act.mode_req == 2'b11);
         if (state_nxt != state) cnt <= '0;
         else if (!(&cnt))       cnt <= cnt + 1'b1;
      end
   end

   assign act.heater_en   = heater_q;
   assign act.cooler_en   = cooler_q;
   assign act.illegal_req = illegal_q;
   assign act.state_o     = state;
   assign act.busy        = (state == DEAD) |
                            (((state == HEAT) | (state == COOL)) & (cnt < ON_LAST));

endmodule

// File: tb/tb_hvac_actuator_seq.sv
// Directed bench for hvac_actuator_seq with MIN_ON=8, DEAD_T=4.
module tb_hvac_actuator_seq;

   typedef struct packed {
      logic [1:0] req;
      logic       heat;
      logic       cool;
      logic       busy;
      logic       ill;
      logic [1:0] st;
   } vec_t;

   localparam int NV = 28;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   vec_t vecs [NV];

   hvac_actuator_seq_if bus ();

   hvac_actuator_seq #(.MIN_ON(8), .DEAD_T(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .act   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [1:0] r, input logic h, input logic c,
                               input logic b, input logic i, input logic [1:0] s);
      vec_t v;
      v.req = r; v.heat = h; v.cool = c; v.busy = b; v.ill = i; v.st = s;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic h, input logic c,
                          input logic b, input logic i, input logic [1:0] s);
      chk({tag, ".heater_en"},   8'(bus.heater_en),   8'(h));
      chk({tag, ".cooler_en"},   8'(bus.cooler_en),   8'(c));
      chk({tag, ".busy"},        8'(bus.busy),        8'(b));
      chk({tag, ".illegal_req"}, 8'(bus.illegal_req), 8'(i));
      chk({tag, ".state_o"},     8'(bus.state_o),     8'(s));
   endtask

   task automatic step(input logic [1:0] r);
      bus.mode_req = r;
      @(posedge clk);
      #1;
   endtask

   // Mutual exclusion of the enables, sampled mid-cycle throughout the run.
   always @(negedge clk) begin
      total++;
      if ((bus.heater_en & bus.cooler_en) !== 1'b0) begin
         bad++;
         $display("FAIL both_enables: heater=%b cooler=%b expected not both high",
                  bus.heater_en, bus.cooler_en);
      end
   end

   initial begin
      // Heat pulse shorter than MIN_ON, then dead-time, then idle.
      vecs[0]  = mk(2'b10, 1, 0, 1, 0, 2'b01);
      vecs[1]  = mk(2'b10, 1, 0, 1, 0, 2'b01);
      vecs[2]  = mk(2'b10, 1, 0, 1, 0, 2'b01);
      vecs[3]  = mk(2'b00, 1, 0, 1, 0, 2'b01);
      vecs[4]  = mk(2'b00, 1, 0, 1, 0, 2'b01);
      vecs[5]  = mk(2'b00, 1, 0, 1, 0, 2'b01);
      vecs[6]  = mk(2'b00, 1, 0, 1, 0, 2'b01);
      vecs[7]  = mk(2'b00, 1, 0, 0, 0, 2'b01);
      vecs[8]  = mk(2'b00, 0, 0, 1, 0, 2'b11);
      vecs[9]  = mk(2'b00, 0, 0, 1, 0, 2'b11);
      vecs[10] = mk(2'b00, 0, 0, 1, 0, 2'b11);
      vecs[11] = mk(2'b00, 0, 0, 1, 0, 2'b11);
      vecs[12] = mk(2'b00, 0, 0, 0, 0, 2'b00);
      // Illegal request in IDLE.
      vecs[13] = mk(2'b11, 0, 0, 0, 1, 2'b00);
      vecs[14] = mk(2'b00, 0, 0, 0, 0, 2'b00);
      // Heat, drop, request toggles during DEAD, re-enter HEAT at DEAD exit.
      vecs[15] = mk(2'b10, 1, 0, 1, 0, 2'b01);
      vecs[16] = mk(2'b00, 1, 0, 1, 0, 2'b01);
      vecs[17] = mk(2'b00, 1, 0, 1, 0, 2'b01);
      vecs[18] = mk(2'b00, 1, 0, 1, 0, 2'b01);
      vecs[19] = mk(2'b00, 1, 0, 1, 0, 2'b01);
      vecs[20] = mk(2'b00, 1, 0, 1, 0, 2'b01);
      vecs[21] = mk(2'b00, 1, 0, 1, 0, 2'b01);
      vecs[22] = mk(2'b00, 1, 0, 0, 0, 2'b01);
      vecs[23] = mk(2'b00, 0, 0, 1, 0, 2'b11);
      vecs[24] = mk(2'b10, 0, 0, 1, 0, 2'b11);
      vecs[25] = mk(2'b00, 0, 0, 1, 0, 2'b11);
      vecs[26] = mk(2'b10, 0, 0, 1, 0, 2'b11);
      vecs[27] = mk(2'b10, 1, 0, 1, 0, 2'b01);

      // Reset with a heat request pending: everything low.
      bus.mode_req = 2'b10;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 0, 0, 0, 0, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all("release", 1, 0, 1, 0, 2'b01);

      // Async reset mid-HEAT, checked between edges.
      step(2'b10);
      step(2'b10);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 2'b00);
      bus.mode_req = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].req);
         chk_all($sformatf("vec%0d", i), vecs[i].heat, vecs[i].cool,
                 vecs[i].busy, vecs[i].ill, vecs[i].st);
      end

      // Long heat, then switch to cool: heater falls, cooler rises 4 edges later.
      @(negedge clk);
      rst_n = 1'b0;
      bus.mode_req = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(2'b10);
         chk("long_heat.heater_en", 8'(bus.heater_en), 8'd1);
      end
      step(2'b01);
      chk_all("heat_off", 0, 0, 1, 0, 2'b11);
      for (int i = 0; i < 3; i++) begin
         step(2'b01);
         chk_all($sformatf("dead%0d", i + 1), 0, 0, 1, 0, 2'b11);
      end
      step(2'b01);
      chk_all("cool_on", 0, 1, 1, 0, 2'b10);
      // Cooler min on-time: request drop ignored for 7 more edges.
      for (int i = 0; i < 7; i++) begin
         step(2'b00);
         chk($sformatf("cool_hold%0d", i), 8'(bus.cooler_en), 8'd1);
      end
      step(2'b00);
      chk_all("cool_off", 0, 0, 1, 0, 2'b11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
